// File: rtl/stack_mem_responder.sv
// Memory-side responder for the stack CPU: program RAM, stack RAM and a small
// I/O page (console TX FIFO, 32-bit cycle counter), with registered read data.
module stack_mem_responder #(
   parameter int PROG_WORDS  = 1024,
   parameter int STACK_WORDS = 256,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] wr_data,
   input  logic        write_memory,
   output logic [15:0] rd_data,
   output logic        bus_fault,
   output logic [15:0] con_data,
   output logic        con_valid,
   input  logic        con_ready
);

   localparam int PA = $clog2(PROG_WORDS);
   localparam int SA = $clog2(STACK_WORDS);
   localparam int FA = $clog2(FIFO_DEPTH);
   localparam int CW = FA + 1;
   localparam logic [16:0] PROG_END   = 17'(32 + PROG_WORDS);
   localparam logic [16:0] STACK_BASE = 17'(65536 - STACK_WORDS);

   typedef enum logic [3:0] {
      REG_CON_TX   = 4'h0,
      REG_CON_STAT = 4'h1,
      REG_CYC_LO   = 4'h2,
      REG_CYC_HI   = 4'h3
   } io_reg_e;

   logic [15:0]   prog_mem  [PROG_WORDS];
   logic [15:0]   stack_mem [STACK_WORDS];
   logic [15:0]   fifo_mem  [FIFO_DEPTH];

   logic [PA-1:0] prog_idx;
   logic [SA-1:0] stack_idx;
   logic [3:0]    io_reg;
   logic          is_io, is_prog, is_stack, is_mapped;

   logic [FA-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          full, empty, ovf;
   logic          push_req, push_ok, pop, ovf_set;

   logic [31:0]   cyc_cnt;
   logic [15:0]   cyc_shadow;
   logic [15:0]   rd_next;
   logic          fault_next;

   // Address decode
   always_comb begin
      io_reg    = addr[3:0];
      is_io     = (addr[15:4] == 12'h000);
      is_prog   = ({1'b0, addr} >= 17'h00020) && ({1'b0, addr} < PROG_END);
      is_stack  = ({1'b0, addr} >= STACK_BASE);
      is_mapped = is_prog || is_stack || (is_io && io_reg < 4'd4);
      prog_idx  = PA'(addr - 16'h0020);
      stack_idx = SA'(addr);
   end

   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign con_valid = !empty;
   assign con_data  = fifo_mem[rd_ptr];

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign pop      = con_valid && con_ready;
   assign push_req = write_memory && is_io && (io_reg == REG_CON_TX);
   assign push_ok  = push_req && (!full || pop);
   assign ovf_set  = push_req && !push_ok;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      rd_next    = 16'h0000;
      fault_next = !is_mapped || ovf_set;
      if (write_memory) begin
         if (is_prog || is_stack)
            rd_next = wr_data;
      end else if (is_prog) begin
         rd_next = prog_mem[prog_idx];
      end else if (is_stack) begin
         rd_next = stack_mem[stack_idx];
      end else if (is_io) begin
         case (io_reg)
            REG_CON_STAT: rd_next = {ovf, full, empty, 5'b0, 8'(count)};
            REG_CYC_LO:   rd_next = cyc_cnt[15:0];
            REG_CYC_HI:   rd_next = cyc_shadow;
            default:      rd_next = 16'h0000;
         endcase
      end
   end

   // NOTE: storage arrays are deliberately not reset; only the write is gated by rst.
   always_ff @(posedge clk) begin
      if (!rst && write_memory && is_prog)
         prog_mem[prog_idx] <= wr_data;
      if (!rst && write_memory && is_stack)
         stack_mem[stack_idx] <= wr_data;
      if (!rst && push_ok)
         fifo_mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data    <= 16'h0000;
         bus_fault  <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ovf        <= 1'b0;
         cyc_cnt    <= 32'h0000_0000;
         cyc_shadow <= 16'h0000;
      end else begin
         rd_data   <= rd_next;
         bus_fault <= fault_next;
         cyc_cnt   <= cyc_cnt + 32'd1;
         if (push_ok)
            wr_ptr <= wr_ptr + FA'(1);
         if (pop)
            rd_ptr <= rd_ptr + FA'(1);
         if (push_ok && !pop)
            count <= count + CW'(1);
         else if (pop && !push_ok)
            count <= count - CW'(1);
         if (ovf_set)
            ovf <= 1'b1;
         else if (write_memory && is_io && io_reg == REG_CON_STAT)
            ovf <= 1'b0;
         if (!write_memory && is_io && io_reg == REG_CYC_LO)
            cyc_shadow <= cyc_cnt[31:16];
      end
   end

endmodule

// File: tb/tb_stack_mem_responder.sv
// Directed bench for stack_mem_responder: an address-level reference model is
// compared every cycle, plus literal expectations taken from hand calculation.
module tb_stack_mem_responder;

   localparam int PW = 1024;
   localparam int SW = 256;
   localparam int FD = 8;

   logic        clk;
   logic        rst;
   logic [15:0] addr;
   logic [15:0] wr_data;
   logic        write_memory;
   logic [15:0] rd_data;
   logic        bus_fault;
   logic [15:0] con_data;
   logic        con_valid;
   logic        con_ready;

   int vectors     = 0;
   int miscompares = 0;

   stack_mem_responder #(.PROG_WORDS(PW), .STACK_WORDS(SW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data),
      .write_memory(write_memory), .rd_data(rd_data), .bus_fault(bus_fault),
      .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: memory as an address-keyed map, FIFO as a queue.
   logic [15:0] m_ram [int];
   logic [15:0] m_fifo [$];
   bit   [31:0] m_cnt;
   bit   [15:0] m_shadow;
   bit          m_ovf;
   bit          m_ready = 0;
   bit          exp_rd_known;
   logic [15:0] exp_rd;
   logic        exp_fault;

   always @(posedge clk) begin
      int a;
      bit in_ram, pop;
      a      = int'(addr);
      in_ram = (a >= 32 && a < 32 + PW) || (a >= 65536 - SW);
      if (rst) begin
         exp_rd = 16'h0; exp_rd_known = 1; exp_fault = 0;
         m_fifo.delete(); m_ovf = 0; m_cnt = 0; m_shadow = 0;
      end else begin
         pop = (m_fifo.size() > 0) && con_ready;
         exp_rd = 16'h0; exp_rd_known = 1;
         exp_fault = !(in_ram || a < 4);
         if (write_memory) begin
            if (in_ram) begin
               m_ram[a] = wr_data;
               exp_rd = wr_data;
            end else if (a == 0) begin
               if (m_fifo.size() == FD && !pop) begin
                  exp_fault = 1; m_ovf = 1;
               end
            end else if (a == 1) begin
               m_ovf = 0;
            end
         end else begin
            if (in_ram) begin
               exp_rd_known = m_ram.exists(a);
               if (exp_rd_known) exp_rd = m_ram[a];
            end else if (a == 1) begin
               exp_rd = {m_ovf, m_fifo.size() == FD, m_fifo.size() == 0, 5'b0, 8'(m_fifo.size())};
            end else if (a == 2) begin
               exp_rd = m_cnt[15:0];
               m_shadow = m_cnt[31:16];
            end else if (a == 3) begin
               exp_rd = m_shadow;
            end
         end
         if (pop) void'(m_fifo.pop_front());
         if (write_memory && a == 0 && !(m_fifo.size() == FD))
            if (!(exp_fault && !in_ram)) m_fifo.push_back(wr_data);
         m_cnt = m_cnt + 1;
      end
      m_ready = 1;
   end

   // Compare process: outputs are sampled on the falling edge.
   always @(negedge clk) begin
      if (m_ready) begin
         if (exp_rd_known) check("rd_data", rd_data, exp_rd);
         check("bus_fault", {15'b0, bus_fault}, {15'b0, exp_fault});
         check("con_valid", {15'b0, con_valid}, {15'b0, m_fifo.size() != 0});
         if (m_fifo.size() != 0) check("con_data", con_data, m_fifo[0]);
      end
   end

   task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      rst = r; write_memory = w; addr = a; wr_data = d;
      @(negedge clk);
   endtask

   task automatic rd(input logic [15:0] a);
      step(1'b0, 1'b0, a, 16'h0000);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      step(1'b0, 1'b1, a, d);
   endtask

   initial begin
      rst = 1'b1; write_memory = 1'b0; addr = 16'h0; wr_data = 16'h0; con_ready = 1'b0;

      // Boot
      step(1'b1, 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b0, 16'h0, 16'h0);
      check("reset_rd_data", rd_data, 16'h0000);
      check("reset_con_valid", {15'b0, con_valid}, 16'h0000);
      rd(16'h0020);
      check("boot_fault", {15'b0, bus_fault}, 16'h0000);
      rd(16'h0000);
      rd(16'h0000);
      rd(16'h0002);
      check("boot_cyc_lo", rd_data, 16'd3);

      // RAM windows
      wr(16'h0020, 16'h1234);
      check("prog_write_first", rd_data, 16'h1234);
      wr(16'hFFFF, 16'hBEEF);
      rd(16'h0020);
      check("prog_read", rd_data, 16'h1234);
      rd(16'hFFFF);
      check("stack_read", rd_data, 16'hBEEF);
      rd(16'h0020 + 16'(PW));
      check("prog_oob_data", rd_data, 16'h0000);
      check("prog_oob_fault", {15'b0, bus_fault}, 16'h0001);
      rd(16'h0000);
      check("fault_one_cycle", {15'b0, bus_fault}, 16'h0000);

      // Stack window edges and other holes in the map
      wr(16'hFF00, 16'hAAAA);
      check("stack_low_ok", {15'b0, bus_fault}, 16'h0000);
      rd(16'hFF00);
      check("stack_low_read", rd_data, 16'hAAAA);
      wr(16'hFEFF, 16'h5555);
      check("below_stack_wr_fault", {15'b0, bus_fault}, 16'h0001);
      rd(16'hFEFF);
      check("below_stack_rd", rd_data, 16'h0000);
      rd(16'h0015);
      check("reserved_fault", {15'b0, bus_fault}, 16'h0001);
      wr(16'h0004, 16'h0001);
      check("io_hole_fault", {15'b0, bus_fault}, 16'h0001);
      wr(16'h0002, 16'h0001);
      check("cyc_write_nofault", {15'b0, bus_fault}, 16'h0000);

      // FIFO fill and overflow
      for (int i = 1; i <= 9; i++) wr(16'h0000, 16'(i));
      check("push_full_fault", {15'b0, bus_fault}, 16'h0001);
      rd(16'h0001);
      check("stat_ovf_full", rd_data, 16'hC008);
      con_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("drain_head", con_data, 16'(i));
         rd(16'h0000);
      end
      check("drained_empty", {15'b0, con_valid}, 16'h0000);
      con_ready = 1'b0;
      wr(16'h0001, 16'h1234);
      rd(16'h0001);
      check("stat_cleared", rd_data, 16'h2000);

      // Push and pop together on a full FIFO
      for (int i = 0; i < 8; i++) wr(16'h0000, 16'h0010 + 16'(i));
      con_ready = 1'b1;
      wr(16'h0000, 16'h00FF);
      check("full_pushpop_fault", {15'b0, bus_fault}, 16'h0000);
      con_ready = 1'b0;
      rd(16'h0001);
      check("full_pushpop_stat", rd_data, 16'h4008);
      con_ready = 1'b1;
      for (int i = 1; i < 8; i++) rd(16'h0000);
      check("last_word", con_data, 16'h00FF);
      rd(16'h0000);
      check("pushpop_empty", {15'b0, con_valid}, 16'h0000);

      // Push while empty with con_ready high: the word lands then leaves
      wr(16'h0000, 16'h0055);
      check("empty_push_valid", {15'b0, con_valid}, 16'h0001);
      check("empty_push_data", con_data, 16'h0055);
      rd(16'h0000);
      con_ready = 1'b0;

      // Counter snapshot across a 16-bit carry
      force dut.cyc_cnt = 32'h0001FFFF;
      m_cnt = 32'h0001FFFF;
      rst = 1'b0; write_memory = 1'b0; addr = 16'h0002;
      #1 release dut.cyc_cnt;
      @(negedge clk);
      check("cyc_lo_snap", rd_data, 16'hFFFF);
      rd(16'h0000);
      rd(16'h0000);
      rd(16'h0003);
      check("cyc_hi_shadow", rd_data, 16'h0001);

      // Reset in the middle of traffic
      wr(16'h0000, 16'h0077);
      wr(16'h0000, 16'h0078);
      step(1'b1, 1'b1, 16'h0020, 16'hDEAD);
      step(1'b1, 1'b1, 16'h0000, 16'h0099);
      check("midreset_fifo", {15'b0, con_valid}, 16'h0000);
      rd(16'h0020);
      check("midreset_ram_kept", rd_data, 16'h1234);
      rd(16'h0001);
      check("midreset_stat", rd_data, 16'h2000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
